// File: rtl/game_ctrl.sv
// Maze game controller: synchronizes start/collision/goal, runs IDLE/PLAY/LOSE/WIN and holds end states.
// Latency: an input first sampled high at edge N takes effect on the state at edge N+2; outputs are registered.
// Backpressure: none; inputs are level signals reduced to single-cycle rising-edge events, held levels count once.
// Configuration: define GAME_CTRL_LIVES_EN to enable multi-life play; undefined, the first collision ends the game.
module game_ctrl #(
    parameter int unsigned HOLD_CYCLES = 300000000,
    parameter int unsigned LIVES       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       collision,
    input  logic       goal,
    output logic       lose_on,
    output logic       win_on,
    output logic       playing,
    output logic [1:0] state,
    output logic [1:0] lives
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_LOSE = 2'b10,
        ST_WIN  = 2'b11
    } state_t;

    // Last hold count before returning to IDLE; the end state lasts HOLD_CYCLES cycles.
    localparam logic [28:0] HOLD_LAST  = 29'(HOLD_CYCLES - 1);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

    // Input bit order in the synchronizer vectors.
    localparam int IDX_START = 0;
    localparam int IDX_COLL  = 1;
    localparam int IDX_GOAL  = 2;

    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_prev;
    logic [2:0]  w_in;
    logic [2:0]  w_edge;
    logic        w_start_edge;
    logic        w_coll_edge;
    logic        w_goal_edge;

    state_t      r_state;
    logic [1:0]  r_lives;
    logic [28:0] r_hold;
    logic        r_lose_on;
    logic        r_win_on;
    logic        r_playing;

    assign w_in = {goal, collision, start};

    // Two-flop synchronizer plus a delayed copy of the synchronized level for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Rising edge: synchronized level high now, low one cycle earlier. Edge flops reset to 0,
    // so a level already high at reset release still produces one event.
    assign w_edge       = r_sync2 & ~r_prev;
    assign w_start_edge = w_edge[IDX_START];
    assign w_coll_edge  = w_edge[IDX_COLL];
    assign w_goal_edge  = w_edge[IDX_GOAL];

    // Game FSM with hold counter, lives and registered status outputs updated together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_lives   <= 2'd0;
            r_hold    <= '0;
            r_lose_on <= 1'b0;
            r_win_on  <= 1'b0;
            r_playing <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_hold    <= '0;
                    r_lose_on <= 1'b0;
                    r_win_on  <= 1'b0;
                    // Collision and goal edges are meaningless before a game starts.
                    if (w_start_edge) begin
                        r_state   <= ST_PLAY;
                        r_lives   <= LIVES_INIT;
                        r_playing <= 1'b1;
                    end else begin
                        r_playing <= 1'b0;
                    end
                end

                ST_PLAY: begin
                    r_hold <= '0;
                    // A collision takes priority; a goal edge in the same cycle is dropped.
                    if (w_coll_edge) begin
`ifdef GAME_CTRL_LIVES_EN
                        if (r_lives > 2'd1) begin
                            r_lives <= r_lives - 2'd1;
                        end else begin
                            r_state   <= ST_LOSE;
                            r_lives   <= 2'd0;
                            r_lose_on <= 1'b1;
                            r_playing <= 1'b0;
                        end
`else
                        r_state   <= ST_LOSE;
                        r_lives   <= 2'd0;
                        r_lose_on <= 1'b1;
                        r_playing <= 1'b0;
`endif
                    end else if (w_goal_edge) begin
                        r_state   <= ST_WIN;
                        r_win_on  <= 1'b1;
                        r_playing <= 1'b0;
`ifndef GAME_CTRL_LIVES_EN
                        // Without life counting the lives output only shows a value while playing.
                        r_lives   <= 2'd0;
`endif
                    end
                end

                ST_LOSE, ST_WIN: begin
                    // All input edges, including start, are ignored until the hold expires.
                    if (r_hold == HOLD_LAST) begin
                        r_state   <= ST_IDLE;
                        r_hold    <= '0;
                        r_lose_on <= 1'b0;
                        r_win_on  <= 1'b0;
                        r_playing <= 1'b0;
                    end else begin
                        r_hold <= r_hold + 29'd1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_lives   <= 2'd0;
                    r_hold    <= '0;
                    r_lose_on <= 1'b0;
                    r_win_on  <= 1'b0;
                    r_playing <= 1'b0;
                end
            endcase
        end
    end

    assign state   = r_state;
    assign lives   = r_lives;
    assign lose_on = r_lose_on;
    assign win_on  = r_win_on;
    assign playing = r_playing;

endmodule
